// File: rtl/modmul_stream.sv
// Streaming (a*b) mod Q with a Barrett pipeline: operand register, then product, quotient estimate,
// partial remainder and final correction, all under one global enable. Optional MODMUL_CHECK_EN adds range_err.
module modmul_stream #(
  parameter int unsigned Q  = 12289,
  parameter int          K  = $clog2(Q),
  parameter int unsigned MU = 32'((64'd1 << (2 * K)) / Q)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_a,
  input  logic [K-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_r
`ifdef MODMUL_CHECK_EN
  ,
  output logic         range_err
`endif
);

  localparam int PW = 2 * K;
  localparam int TW = 2 * K + 2;
  localparam int RW = K + 2;

  localparam logic [RW-1:0] Q_R  = RW'(Q);
  localparam logic [TW-1:0] MU_T = TW'(MU);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high; the whole
  // pipeline moves together whenever the output slot is empty or being drained (w_adv).
  logic w_adv;
  assign w_adv    = !r_v4 || out_ready;
  assign in_ready = w_adv;

  // Operand register: gives the accept-to-result latency of four edges.
  logic          r_v0;
  logic [K-1:0]  r_a;
  logic [K-1:0]  r_b;

  logic          r_v1;
  logic [PW-1:0] r_p1;

  logic          r_v2;
  logic [K:0]    r_qh2;
  logic [RW-1:0] r_p2;

  logic          r_v3;
  logic [RW-1:0] r_r3;

  logic          r_v4;
  logic [K-1:0]  r_out;

  logic [PW-1:0] w_prod;
  logic [K:0]    w_phi;
  logic [TW-1:0] w_t;
  logic [RW-1:0] w_qq;
  logic [RW-1:0] w_r;
  logic [RW-1:0] w_s1;
  logic [K-1:0]  w_s2;

  assign w_prod = PW'(r_a) * PW'(r_b);
  assign w_phi  = r_p1[PW-1:K-1];
  assign w_t    = TW'(w_phi) * MU_T;
  // Only the low K+2 bits of p - qh*Q matter since the true remainder is below 3Q < 2^(K+2).
  assign w_qq   = RW'(r_qh2) * Q_R;
  assign w_r    = r_p2 - w_qq;
  assign w_s1   = (r_r3 >= Q_R) ? (r_r3 - Q_R) : r_r3;
  assign w_s2   = K'((w_s1 >= Q_R) ? (w_s1 - Q_R) : w_s1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v0  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_v1  <= 1'b0;
      r_p1  <= '0;
      r_v2  <= 1'b0;
      r_qh2 <= '0;
      r_p2  <= '0;
      r_v3  <= 1'b0;
      r_r3  <= '0;
      r_v4  <= 1'b0;
      r_out <= '0;
    end else if (w_adv) begin
      r_v0 <= in_valid;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
      if (in_valid) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (r_v0) r_p1 <= w_prod;
      if (r_v1) begin
        r_qh2 <= (K+1)'(w_t >> (K + 1));
        r_p2  <= r_p1[RW-1:0];
      end
      if (r_v2) r_r3 <= w_r;
      if (r_v3) r_out <= w_s2;
    end
  end

  assign out_valid = r_v4;
  assign out_r     = r_out;

`ifdef MODMUL_CHECK_EN
  localparam logic [K-1:0] Q_K = K'(Q);

  logic r_range_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_range_err <= 1'b0;
    end else if (in_valid && w_adv && ((in_a >= Q_K) || (in_b >= Q_K))) begin
      r_range_err <= 1'b1;
    end
  end

  assign range_err = r_range_err;
`endif

endmodule
